// File: rtl/extbus_sync_if.sv
// Register-file side of the host bus port: address, write data, strobes and read-back data.
// The bridge drives through the master modport and the register file answers through slave.
interface extbus_sync_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8
);
    logic [ADDR_W-1:0] bus_addr;
    logic [DATA_W-1:0] bus_wrdata;
    logic              bus_write;
    logic              bus_read;
    logic [DATA_W-1:0] bus_rddata;

    modport master (
        output bus_addr,
        output bus_wrdata,
        output bus_write,
        output bus_read,
        input  bus_rddata
    );

    modport slave (
        input  bus_addr,
        input  bus_wrdata,
        input  bus_write,
        input  bus_read,
        output bus_rddata
    );
endinterface

// File: rtl/extbus_sync.sv
// Host CPU bus front-end: synchronises the asynchronous bus into clk25 and issues one strobe per access.
// Optional macro EXTBUS_GLITCH_FILTER_EN requires MIN_ACCESS stable cycles before an access is accepted.
module extbus_sync #(
    parameter int ADDR_W      = 5,
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2,
    parameter int MIN_ACCESS  = 2
) (
    input  logic              clk25,
    input  logic              rst_n,
    input  logic              extbus_cs_n,
    input  logic              extbus_rd_n,
    input  logic              extbus_wr_n,
    input  logic [ADDR_W-1:0] extbus_a,
    input  logic [DATA_W-1:0] extbus_d_in,
    output logic [DATA_W-1:0] extbus_d_out,
    output logic              extbus_d_oe,
    extbus_sync_if.master     bus
);

    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("extbus_sync: SYNC_STAGES must be at least 2");
    end
    if (MIN_ACCESS < 1) begin : g_bad_min
        $error("extbus_sync: MIN_ACCESS must be at least 1");
    end

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_REQ  = 2'd1,
        RD_HOLD = 2'd2,
        WR_HOLD = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [SYNC_STAGES-1:0]             cs_sync, rd_sync, wr_sync;
    logic [SYNC_STAGES-1:0][ADDR_W-1:0] a_sync;
    logic [SYNC_STAGES-1:0][DATA_W-1:0] d_sync;

    logic              cs_s, rd_s, wr_s;
    logic [ADDR_W-1:0] a_s;
    logic [DATA_W-1:0] d_s;
    logic              rd_act, wr_act, act_ok;

    logic              start_rd, start_wr, cap_rd, end_rd, commit_wr;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    // Control, address and data share the same depth so they stay aligned after synchronisation
    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) begin
            cs_sync <= '1;
            rd_sync <= '1;
            wr_sync <= '1;
            a_sync  <= '0;
            d_sync  <= '0;
        end else begin
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], extbus_cs_n};
            rd_sync   <= {rd_sync[SYNC_STAGES-2:0], extbus_rd_n};
            wr_sync   <= {wr_sync[SYNC_STAGES-2:0], extbus_wr_n};
            a_sync[0] <= extbus_a;
            d_sync[0] <= extbus_d_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                a_sync[i] <= a_sync[i-1];
                d_sync[i] <= d_sync[i-1];
            end
        end
    end

    assign cs_s   = cs_sync[SYNC_STAGES-1];
    assign rd_s   = rd_sync[SYNC_STAGES-1];
    assign wr_s   = wr_sync[SYNC_STAGES-1];
    assign a_s    = a_sync[SYNC_STAGES-1];
    assign d_s    = d_sync[SYNC_STAGES-1];
    assign rd_act = ~cs_s & ~rd_s &  wr_s;
    assign wr_act = ~cs_s & ~wr_s &  rd_s;

`ifdef EXTBUS_GLITCH_FILTER_EN
    localparam int CNT_W = $clog2(MIN_ACCESS + 1);

    logic [1:0]       act_prev;
    logic [CNT_W-1:0] run_q, run_d;

    // run_d is the length of the current run of identical activity, saturating at MIN_ACCESS
    always_comb begin
        run_d = run_q;
        if ({rd_act, wr_act} != act_prev) begin
            run_d = CNT_W'(1);
        end else if (run_q < CNT_W'(MIN_ACCESS)) begin
            run_d = run_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) begin
            act_prev <= 2'b00;
            run_q    <= '0;
        end else begin
            act_prev <= {rd_act, wr_act};
            run_q    <= run_d;
        end
    end

    assign act_ok = (run_d >= CNT_W'(MIN_ACCESS));
`else
    assign act_ok = 1'b1;
`endif

    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        start_rd  = 1'b0;
        start_wr  = 1'b0;
        cap_rd    = 1'b0;
        end_rd    = 1'b0;
        commit_wr = 1'b0;
        case (state_q)
            IDLE: begin
                if (rd_act && act_ok) begin
                    state_d  = RD_REQ;
                    start_rd = 1'b1;
                end else if (wr_act && act_ok) begin
                    state_d  = WR_HOLD;
                    start_wr = 1'b1;
                end
            end
            RD_REQ: begin
                state_d = RD_HOLD;
                cap_rd  = 1'b1;
            end
            RD_HOLD: begin
                if (!rd_act) begin
                    state_d = IDLE;
                    end_rd  = 1'b1;
                end
            end
            WR_HOLD: begin
                if (!wr_act) begin
                    state_d   = IDLE;
                    commit_wr = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Write address/data keep tracking the host until the strobe drops, so late data setup is honoured
    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) begin
            wr_addr <= '0;
            wr_data <= '0;
        end else if (start_wr || (state_q == WR_HOLD && wr_act)) begin
            wr_addr <= a_s;
            wr_data <= d_s;
        end
    end

    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) begin
            bus.bus_read   <= 1'b0;
            bus.bus_write  <= 1'b0;
            bus.bus_addr   <= '0;
            bus.bus_wrdata <= '0;
            extbus_d_out   <= '0;
            extbus_d_oe    <= 1'b0;
        end else begin
            bus.bus_read  <= start_rd;
            bus.bus_write <= commit_wr;
            if (start_rd) begin
                bus.bus_addr <= a_s;
            end else if (commit_wr) begin
                bus.bus_addr   <= wr_addr;
                bus.bus_wrdata <= wr_data;
            end
            if (cap_rd) begin
                extbus_d_out <= bus.bus_rddata;
                extbus_d_oe  <= 1'b1;
            end else if (end_rd) begin
                extbus_d_oe  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_extbus_sync.sv
// Scoreboard bench for extbus_sync: host accesses push expected strobes, a negedge monitor pops and checks.
// Expectations follow EXTBUS_GLITCH_FILTER_EN when the bench is compiled with it.
module tb_extbus_sync;

    localparam int ADDR_W      = 5;
    localparam int DATA_W      = 8;
    localparam int SYNC_STAGES = 2;
    localparam int MIN_ACCESS  = 2;
`ifdef EXTBUS_GLITCH_FILTER_EN
    localparam int RD_LAT = SYNC_STAGES + MIN_ACCESS;
`else
    localparam int RD_LAT = SYNC_STAGES + 1;
`endif

    typedef struct packed {
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } txn_t;

    logic              clk25;
    logic              rst_n;
    logic              extbus_cs_n, extbus_rd_n, extbus_wr_n;
    logic [ADDR_W-1:0] extbus_a;
    logic [DATA_W-1:0] extbus_d_in;
    logic [DATA_W-1:0] extbus_d_out;
    logic              extbus_d_oe;
    logic [DATA_W-1:0] mem [32];

    txn_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   rd_start_cyc = 0;
    int   rel_cyc = 0;
    int   rd_strobe_cyc = 0;
    logic rd_pending = 1'b0;
    logic [DATA_W-1:0] rd_exp_data = '0;
    logic oe_prev = 1'b0;

    extbus_sync_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus_if ();

    extbus_sync #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SYNC_STAGES(SYNC_STAGES), .MIN_ACCESS(MIN_ACCESS)
    ) dut (
        .clk25       (clk25),
        .rst_n       (rst_n),
        .extbus_cs_n (extbus_cs_n),
        .extbus_rd_n (extbus_rd_n),
        .extbus_wr_n (extbus_wr_n),
        .extbus_a    (extbus_a),
        .extbus_d_in (extbus_d_in),
        .extbus_d_out(extbus_d_out),
        .extbus_d_oe (extbus_d_oe),
        .bus         (bus_if)
    );

    assign bus_if.bus_rddata = mem[bus_if.bus_addr];

    initial clk25 = 1'b0;
    always #20 clk25 = ~clk25;

    always @(posedge clk25) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=0x%0h exp=0x%0h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    // Register-file side monitor: pops the scoreboard on every strobe and follows the pad enable
    always @(negedge clk25) begin
        txn_t t;
        if (rst_n) begin
            checkOutput("rd_wr_excl", 32'(bus_if.bus_read & bus_if.bus_write), 32'd0);
            if (bus_if.bus_read || bus_if.bus_write) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_strobe", {30'd0, bus_if.bus_write, bus_if.bus_read}, 32'd0);
                end else begin
                    t = exp_q.pop_front();
                    checkOutput("strobe_kind", 32'(bus_if.bus_write), 32'(t.wr));
                    checkOutput("strobe_addr", 32'(bus_if.bus_addr), 32'(t.addr));
                    if (t.wr) begin
                        checkOutput("wrdata", 32'(bus_if.bus_wrdata), 32'(t.data));
                    end else begin
                        checkOutput("rd_latency", 32'(cyc - rd_start_cyc), 32'(RD_LAT));
                        rd_pending    = 1'b1;
                        rd_exp_data   = t.data;
                        rd_strobe_cyc = cyc;
                    end
                end
            end
            if (extbus_d_oe && !oe_prev) begin
                checkOutput("oe_without_read", 32'(rd_pending), 32'd1);
                checkOutput("oe_latency", 32'(cyc - rd_strobe_cyc), 32'd1);
                rd_pending = 1'b0;
            end
            if (extbus_d_oe) begin
                checkOutput("d_out", 32'(extbus_d_out), 32'(rd_exp_data));
            end
            if (!extbus_d_oe && oe_prev) begin
                checkOutput("oe_fall_latency", 32'(cyc - rel_cyc), 32'(SYNC_STAGES + 1));
            end
        end
        oe_prev = extbus_d_oe;
    end

    task automatic applyStimulus(input logic cs_n, input logic rd_n, input logic wr_n,
                                 input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        @(negedge clk25);
        extbus_cs_n = cs_n;
        extbus_rd_n = rd_n;
        extbus_wr_n = wr_n;
        extbus_a    = a;
        extbus_d_in = d;
    endtask

    task automatic idleCycles(input int n);
        applyStimulus(1'b1, 1'b1, 1'b1, '0, '0);
        repeat (n) @(negedge clk25);
    endtask

    task automatic doRead(input logic [ADDR_W-1:0] a, input int hold);
        exp_q.push_back({1'b0, a, mem[a]});
        applyStimulus(1'b0, 1'b0, 1'b1, a, '0);
        rd_start_cyc = cyc;
        repeat (hold - 1) @(negedge clk25);
        applyStimulus(1'b1, 1'b1, 1'b1, '0, '0);
        rel_cyc = cyc;
        repeat (8) @(negedge clk25);
    endtask

    task automatic doWrite(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                           input int hold, input logic late_data);
        exp_q.push_back({1'b1, a, d});
        applyStimulus(1'b0, 1'b1, 1'b0, a, late_data ? '0 : d);
        if (late_data) begin
            repeat (2) @(negedge clk25);
            extbus_d_in = d;
            repeat (hold - 3) @(negedge clk25);
        end else begin
            repeat (hold - 1) @(negedge clk25);
        end
        applyStimulus(1'b1, 1'b1, 1'b1, '0, '0);
        repeat (8) @(negedge clk25);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog expired, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 8'(i * 7 + 8'h11);
        mem[3] = 8'hA5;
        rst_n       = 1'b1;
        extbus_cs_n = 1'b1;
        extbus_rd_n = 1'b1;
        extbus_wr_n = 1'b1;
        extbus_a    = '0;
        extbus_d_in = '0;
        #5 rst_n = 1'b0;
        repeat (3) @(negedge clk25);
        checkOutput("rst_d_oe", 32'(extbus_d_oe), 32'd0);
        checkOutput("rst_d_out", 32'(extbus_d_out), 32'd0);
        checkOutput("rst_bus_read", 32'(bus_if.bus_read), 32'd0);
        checkOutput("rst_bus_write", 32'(bus_if.bus_write), 32'd0);
        checkOutput("rst_bus_addr", 32'(bus_if.bus_addr), 32'd0);
        checkOutput("rst_bus_wrdata", 32'(bus_if.bus_wrdata), 32'd0);
        rst_n = 1'b1;
        idleCycles(5);

        doRead(5'h03, 8);
        doWrite(5'h1F, 8'h3C, 8, 1'b1);
        doWrite(5'h0C, 8'h81, 6, 1'b0);
        doRead(5'h0A, 100);

        // Both strobes low: no strobe and the pad stays undriven
        applyStimulus(1'b0, 1'b0, 1'b0, 5'h03, 8'hEE);
        repeat (6) @(negedge clk25);
        checkOutput("illegal_oe", 32'(extbus_d_oe), 32'd0);
        idleCycles(6);

        // Read flips straight into a write without releasing chip select
        exp_q.push_back({1'b0, 5'h05, mem[5]});
        exp_q.push_back({1'b1, 5'h06, 8'h77});
        applyStimulus(1'b0, 1'b0, 1'b1, 5'h05, '0);
        rd_start_cyc = cyc;
        repeat (7) @(negedge clk25);
        applyStimulus(1'b0, 1'b1, 1'b0, 5'h06, 8'h77);
        rel_cyc = cyc;
        repeat (9) @(negedge clk25);
        idleCycles(8);

        // Single-cycle write pulse is a glitch only when the filter is built in
`ifndef EXTBUS_GLITCH_FILTER_EN
        exp_q.push_back({1'b1, 5'h02, 8'h55});
`endif
        applyStimulus(1'b0, 1'b1, 1'b0, 5'h02, 8'h55);
        idleCycles(8);
        doWrite(5'h04, 8'h99, 3, 1'b0);

        // Reset while the pad is driven
        exp_q.push_back({1'b0, 5'h07, mem[7]});
        applyStimulus(1'b0, 1'b0, 1'b1, 5'h07, '0);
        rd_start_cyc = cyc;
        for (int i = 0; i < 40 && !extbus_d_oe; i++) @(negedge clk25);
        checkOutput("oe_before_reset", 32'(extbus_d_oe), 32'd1);
        repeat (2) @(negedge clk25);
        #7 rst_n = 1'b0;
        #1;
        checkOutput("rst_async_oe", 32'(extbus_d_oe), 32'd0);
        checkOutput("rst_async_read", 32'(bus_if.bus_read), 32'd0);
        applyStimulus(1'b1, 1'b1, 1'b1, '0, '0);
        repeat (3) @(negedge clk25);
        rst_n = 1'b1;
        idleCycles(20);
        checkOutput("post_rst_oe", 32'(extbus_d_oe), 32'd0);

        doRead(5'h03, 6);
        doWrite(5'h11, 8'h42, 5, 1'b0);
        idleCycles(5);

        checkOutput("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
